// File: rtl/ip_tx_pkg.sv
// Shared types and constants for the IP transmit scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ip_tx_pkg;

    // Scheduler state encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_SENT  = 2'd2,
        ST_BUSY  = 2'd3
    } tx_state_t;

    // Client indices
    localparam logic CLI_ICMP = 1'b0;
    localparam logic CLI_UDP  = 1'b1;

    // IP protocol numbers used by the two clients
    localparam logic [7:0] PROTO_ICMP = 8'h01;
    localparam logic [7:0] PROTO_UDP  = 8'h11;

    // Transmit-buffer offset used by the ICMP echo-reply engine
    localparam logic [2:0] ICMP_OFFSET = 3'b100;

    // One client's RAM write bus plus its send request and attributes
    typedef struct packed {
        logic        wr_ram;
        logic [7:0]  wr_data;
        logic [7:0]  wr_addr;
        logic        send;
        logic [15:0] size;
        logic [31:0] dest_ip;
        logic [2:0]  offset;
        logic [7:0]  protocol;
    } tx_bus_t;

endpackage

// File: rtl/tx_rr_arb2.sv
// Two-input round-robin picker: chooses a requester, favouring the one not served last.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
// Ports: req[1:0] requests, last = index served most recently,
//        valid = some request present, pick = chosen index.
module tx_rr_arb2
    import ip_tx_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       pick
);

    always_comb begin
        valid = |req;
        // With a single requester it wins outright; on contention the
        // client that was not served last goes first.
        if (req == 2'b11) begin
            pick = ~last;
        end else begin
            pick = req[1];
        end
    end

endmodule

// File: rtl/ip_tx_scheduler.sv
// Shares the IP transmit path (TX RAM write port + sendDatagram) between the ICMP and UDP clients.
// Latency: grant one edge after req is seen in IDLE; write/send path is zero-latency pass-through.
// Backpressure: a grant is held through send and IP busy; stalled grants are revoked by a watchdog.
// Ports: cN_* client N request/write/send inputs and grant/complete outputs; ram_complete and
//        ip_busy from downstream; muxed wrRAM/wrData/wrAddr and send attributes to the IP layer;
//        timeout_err pulses for the cycle in which the watchdog revokes a grant.
module ip_tx_scheduler
    import ip_tx_pkg::*;
#(
    parameter int TIMEOUT = 4096,
    parameter int TW      = 13
)
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        c0_req,
    output logic        c0_gnt,
    output logic        c0_complete,
    input  logic        c0_wrRAM,
    input  logic [7:0]  c0_wrData,
    input  logic [7:0]  c0_wrAddr,
    input  logic        c0_sendDatagram,
    input  logic [15:0] c0_sendDatagramSize,
    input  logic [31:0] c0_destinationIP,
    input  logic [2:0]  c0_addressOffset,
    input  logic [7:0]  c0_protocol,
    input  logic        c1_req,
    output logic        c1_gnt,
    output logic        c1_complete,
    input  logic        c1_wrRAM,
    input  logic [7:0]  c1_wrData,
    input  logic [7:0]  c1_wrAddr,
    input  logic        c1_sendDatagram,
    input  logic [15:0] c1_sendDatagramSize,
    input  logic [31:0] c1_destinationIP,
    input  logic [2:0]  c1_addressOffset,
    input  logic [7:0]  c1_protocol,
    input  logic        ram_complete,
    output logic        wrRAM,
    output logic [7:0]  wrData,
    output logic [7:0]  wrAddr,
    output logic        sendDatagram,
    output logic [15:0] sendDatagramSize,
    output logic [31:0] destinationIP,
    output logic [2:0]  addressOffset,
    output logic [7:0]  protocolOut,
    input  logic        ip_busy,
    output logic        timeout_err
);

    localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);

    tx_state_t     state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic [TW-1:0] wd_q, wd_d;
    logic          c0_gnt_q, c0_gnt_d;
    logic          c1_gnt_q, c1_gnt_d;

    logic          arb_valid, arb_pick;
    logic          own_req, wd_expired;
    tx_bus_t       c0_bus, c1_bus, own_bus, out_bus;

    tx_rr_arb2 u_arb (
        .req   ({c1_req, c0_req}),
        .last  (last_q),
        .valid (arb_valid),
        .pick  (arb_pick)
    );

    always_comb begin
        c0_bus = '{wr_ram: c0_wrRAM, wr_data: c0_wrData, wr_addr: c0_wrAddr,
                   send: c0_sendDatagram, size: c0_sendDatagramSize,
                   dest_ip: c0_destinationIP, offset: c0_addressOffset,
                   protocol: c0_protocol};
        c1_bus = '{wr_ram: c1_wrRAM, wr_data: c1_wrData, wr_addr: c1_wrAddr,
                   send: c1_sendDatagram, size: c1_sendDatagramSize,
                   dest_ip: c1_destinationIP, offset: c1_addressOffset,
                   protocol: c1_protocol};
        own_bus    = (owner_q == CLI_UDP) ? c1_bus : c0_bus;
        own_req    = (owner_q == CLI_UDP) ? c1_req : c0_req;
        // Only the GRANT phase exposes the owner's bus; this is also what
        // drops repeat send pulses once the datagram has been launched.
        out_bus    = (state_q == ST_GRANT) ? own_bus : '0;
        wd_expired = (wd_q == WD_LAST);
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        wd_d        = wd_q;
        timeout_err = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    state_d = ST_GRANT;
                    owner_d = arb_pick;
                    last_d  = arb_pick;
                    wd_d    = '0;
                end
            end
            ST_GRANT: begin
                // A send in the same cycle as req falling still counts as a send.
                if (own_bus.send) begin
                    state_d = ST_SENT;
                    wd_d    = '0;
                end else if (!own_req) begin
                    state_d = ST_IDLE;
                end else if (wd_expired) begin
                    state_d     = ST_IDLE;
                    timeout_err = 1'b1;
                end else begin
                    wd_d = wd_q + TW'(1);
                end
            end
            ST_SENT: begin
                if (ip_busy) begin
                    state_d = ST_BUSY;
                end else if (wd_expired) begin
                    state_d     = ST_IDLE;
                    timeout_err = 1'b1;
                end else begin
                    wd_d = wd_q + TW'(1);
                end
            end
            ST_BUSY: begin
                if (!ip_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        c0_gnt_d = (state_d != ST_IDLE) && (owner_d == CLI_ICMP);
        c1_gnt_d = (state_d != ST_IDLE) && (owner_d == CLI_UDP);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            owner_q  <= CLI_ICMP;
            last_q   <= 1'b1;
            wd_q     <= '0;
            c0_gnt_q <= 1'b0;
            c1_gnt_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            wd_q     <= wd_d;
            c0_gnt_q <= c0_gnt_d;
            c1_gnt_q <= c1_gnt_d;
        end
    end

    assign c0_gnt           = c0_gnt_q;
    assign c1_gnt           = c1_gnt_q;
    assign c0_complete      = c0_gnt_q & ram_complete;
    assign c1_complete      = c1_gnt_q & ram_complete;
    assign wrRAM            = out_bus.wr_ram;
    assign wrData           = out_bus.wr_data;
    assign wrAddr           = out_bus.wr_addr;
    assign sendDatagram     = out_bus.send;
    assign sendDatagramSize = out_bus.size;
    assign destinationIP    = out_bus.dest_ip;
    assign addressOffset    = out_bus.offset;
    assign protocolOut      = out_bus.protocol;

endmodule

// File: tb/tb_ip_tx_scheduler.sv
// Self-checking bench for ip_tx_scheduler (TIMEOUT=16).
// Latency: n/a.
// Backpressure: n/a.
module tb_ip_tx_scheduler;
    import ip_tx_pkg::*;

    localparam int TO  = 16;
    localparam int TWB = 5;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic [1:0]  req, wr, snd;
    logic [7:0]  wdat [2];
    logic [7:0]  waddr [2];
    logic [7:0]  proto [2];
    logic [15:0] size [2];
    logic [31:0] dest [2];
    logic [2:0]  off [2];
    logic        ram_complete, ip_busy;

    logic        c0_gnt, c1_gnt, c0_complete, c1_complete;
    logic        wrRAM, sendDatagram, timeout_err;
    logic [7:0]  wrData, wrAddr, protocolOut;
    logic [15:0] sendDatagramSize;
    logic [31:0] destinationIP;
    logic [2:0]  addressOffset;

    ip_tx_scheduler #(.TIMEOUT(TO), .TW(TWB)) dut (
        .clk(clk), .reset_n(reset_n),
        .c0_req(req[0]), .c0_gnt(c0_gnt), .c0_complete(c0_complete),
        .c0_wrRAM(wr[0]), .c0_wrData(wdat[0]), .c0_wrAddr(waddr[0]),
        .c0_sendDatagram(snd[0]), .c0_sendDatagramSize(size[0]),
        .c0_destinationIP(dest[0]), .c0_addressOffset(off[0]), .c0_protocol(proto[0]),
        .c1_req(req[1]), .c1_gnt(c1_gnt), .c1_complete(c1_complete),
        .c1_wrRAM(wr[1]), .c1_wrData(wdat[1]), .c1_wrAddr(waddr[1]),
        .c1_sendDatagram(snd[1]), .c1_sendDatagramSize(size[1]),
        .c1_destinationIP(dest[1]), .c1_addressOffset(off[1]), .c1_protocol(proto[1]),
        .ram_complete(ram_complete),
        .wrRAM(wrRAM), .wrData(wrData), .wrAddr(wrAddr),
        .sendDatagram(sendDatagram), .sendDatagramSize(sendDatagramSize),
        .destinationIP(destinationIP), .addressOffset(addressOffset),
        .protocolOut(protocolOut),
        .ip_busy(ip_busy), .timeout_err(timeout_err)
    );

    typedef struct packed {
        logic [1:0]  gnt;
        logic [1:0]  cmp;
        logic        wr;
        logic [7:0]  dat;
        logic [7:0]  addr;
        logic        snd;
        logic [15:0] size;
        logic [31:0] dest;
        logic [2:0]  off;
        logic [7:0]  proto;
        logic        tmo;
    } obs_t;

    int checks = 0;
    int errors = 0;

    // Reference model: who holds the path, whether the datagram has been
    // launched, whether the IP layer has picked it up, and cycles spent waiting.
    int holder;   // -1 when nobody holds the path
    bit launched;
    bit on_air;
    int age;
    int prefer;   // client that wins a tie next time

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic obs_t observe();
        obs_t o;
        o.gnt = {c1_gnt, c0_gnt};         o.cmp = {c1_complete, c0_complete};
        o.wr = wrRAM;                     o.dat = wrData;
        o.addr = wrAddr;                  o.snd = sendDatagram;
        o.size = sendDatagramSize;        o.dest = destinationIP;
        o.off = addressOffset;            o.proto = protocolOut;
        o.tmo = timeout_err;
        return o;
    endfunction

    function automatic obs_t model_out();
        obs_t o = '0;
        if (holder >= 0) begin
            o.gnt[holder] = 1'b1;
            o.cmp[holder] = ram_complete;
            if (!launched) begin
                o.wr = wr[holder];      o.dat = wdat[holder];
                o.addr = waddr[holder]; o.snd = snd[holder];
                o.size = size[holder];  o.dest = dest[holder];
                o.off = off[holder];    o.proto = proto[holder];
            end
            if (!on_air && age == TO - 1)
                o.tmo = launched ? !ip_busy : (req[holder] && !snd[holder]);
        end
        return o;
    endfunction

    task automatic model_reset();
        holder = -1; launched = 0; on_air = 0; age = 0; prefer = 0;
    endtask

    task automatic model_step();
        if (holder < 0) begin
            if (req != 2'b00) begin
                holder = (req == 2'b11) ? prefer : (req[0] ? 0 : 1);
                prefer = 1 - holder;
                launched = 0; on_air = 0; age = 0;
            end
        end else if (!launched) begin
            if (snd[holder]) begin launched = 1; age = 0; end
            else if (!req[holder] || age == TO - 1) holder = -1;
            else age++;
        end else if (!on_air) begin
            if (ip_busy) on_air = 1;
            else if (age == TO - 1) holder = -1;
            else age++;
        end else if (!ip_busy) begin
            holder = -1;
        end
    endtask

    // Entered at posedge+1; compares at posedge+4 with data fields masked
    // outside the write phase, where only the strobes are defined.
    task automatic sample_check(input string name);
        obs_t a, e;
        #3;
        a = observe();
        e = model_out();
        if (!(holder >= 0 && !launched)) begin
            a.dat = '0; a.addr = '0; a.size = '0; a.dest = '0; a.off = '0; a.proto = '0;
            e.dat = '0; e.addr = '0; e.size = '0; e.dest = '0; e.off = '0; e.proto = '0;
        end
        chk(name, 128'(a), 128'(e));
    endtask

    task automatic tick();
        @(posedge clk); #1;
        model_step();
    endtask

    task automatic set_defaults();
        req = '0; wr = '0; snd = '0; ram_complete = 0; ip_busy = 0;
        wdat[0] = 8'h00; waddr[0] = 8'h00; size[0] = 16'h0000;
        dest[0] = 32'hC0A8_0001; off[0] = ICMP_OFFSET; proto[0] = PROTO_ICMP;
        wdat[1] = 8'hEE; waddr[1] = 8'h77; size[1] = 16'h0123;
        dest[1] = 32'h0A00_0001; off[1] = 3'b000; proto[1] = PROTO_UDP;
    endtask

    task automatic do_reset();
        set_defaults();
        reset_n = 0;
        @(posedge clk); #1;
        reset_n = 1;
        model_reset();
    endtask

    // {rep, r0,w0,s0,r1,w1,s1,rc,busy, a0, sz0, ectl={g0,g1,wr,snd,cmp0,cmp1,tmo}, eaddr, esz}
    typedef struct {
        int          rep;
        logic        r0, w0, s0, r1, w1, s1, rc, busy;
        logic [7:0]  a0;
        logic [15:0] sz0;
        logic [6:0]  ectl;
        logic [7:0]  eaddr;
        logic [15:0] esz;
    } vec_t;

    vec_t vt [9];

    initial begin
        int pulses, held;
        vt[0] = '{1, 1,0,0, 0,0,0, 0,0, 8'h00, 16'h0000, 7'b0000000, 8'h00, 16'h0000};
        vt[1] = '{1, 1,0,0, 0,0,0, 0,0, 8'h00, 16'h0000, 7'b1000000, 8'h00, 16'h0000};
        vt[2] = '{1, 1,1,0, 0,1,1, 1,0, 8'h22, 16'h0000, 7'b1010100, 8'h22, 16'h0000};
        vt[3] = '{1, 1,0,1, 0,0,0, 0,0, 8'h00, 16'h0040, 7'b1001000, 8'h00, 16'h0040};
        vt[4] = '{1, 1,0,1, 0,0,0, 0,0, 8'h00, 16'h0040, 7'b1000000, 8'h00, 16'h0000};
        vt[5] = '{1, 1,0,0, 0,0,0, 0,1, 8'h00, 16'h0000, 7'b1000000, 8'h00, 16'h0000};
        vt[6] = '{9, 1,0,0, 1,1,1, 1,1, 8'h00, 16'h0000, 7'b1000100, 8'h00, 16'h0000};
        vt[7] = '{1, 0,0,0, 0,0,0, 0,0, 8'h00, 16'h0000, 7'b1000000, 8'h00, 16'h0000};
        vt[8] = '{1, 0,0,0, 0,0,0, 0,0, 8'h00, 16'h0000, 7'b0000000, 8'h00, 16'h0000};

        // Reset state
        set_defaults();
        reset_n = 0;
        model_reset();
        #3;
        chk("reset_out", 128'(observe()), 128'(0));
        @(posedge clk); #1;
        reset_n = 1;

        // Table: single ICMP transaction, non-owner noise, repeat send, busy hold
        for (int i = 0; i < 9; i++) begin
            for (int k = 0; k < vt[i].rep; k++) begin
                req = {vt[i].r1, vt[i].r0}; wr = {vt[i].w1, vt[i].w0};
                snd = {vt[i].s1, vt[i].s0}; ram_complete = vt[i].rc; ip_busy = vt[i].busy;
                waddr[0] = vt[i].a0; size[0] = vt[i].sz0;
                #3;
                chk($sformatf("vec%0d_ctl", i),
                    128'({c0_gnt, c1_gnt, wrRAM, sendDatagram, c0_complete, c1_complete, timeout_err}),
                    128'(vt[i].ectl));
                if (vt[i].ectl[4])
                    chk($sformatf("vec%0d_wbus", i), 128'({wrAddr, wrData}), 128'({vt[i].eaddr, 8'h00}));
                if (vt[i].ectl[3])
                    chk($sformatf("vec%0d_send", i), 128'({sendDatagramSize, protocolOut, addressOffset}),
                        128'({vt[i].esz, 8'h01, 3'b100}));
                @(posedge clk); #1;
            end
        end

        // Alternation on simultaneous requests
        do_reset();
        req = 2'b11;
        sample_check("alt_idle"); tick();
        chk("alt_first", 128'({c1_gnt, c0_gnt}), 128'(2'b01));
        for (int c = 0; c < 2; c++) begin
            snd[c] = 1; sample_check("alt_send"); tick();
            snd[c] = 0; ip_busy = 1; sample_check("alt_sent"); tick();
            ip_busy = 0; sample_check("alt_busy"); tick();
            chk("alt_gap", 128'({c1_gnt, c0_gnt}), 128'(2'b00));
            sample_check("alt_idle2"); tick();
            chk($sformatf("alt_next%0d", c), 128'({c1_gnt, c0_gnt}), 128'(c == 0 ? 2'b10 : 2'b01));
        end

        // Owner abandons in GRANT
        do_reset();
        req = 2'b01;
        sample_check("drop_idle"); tick();
        req = 2'b00;
        #3;
        chk("drop_nosend", 128'({sendDatagram, timeout_err}), 128'(2'b00));
        #0; @(posedge clk); #1; model_step();
        chk("drop_idle_gnt", 128'({c1_gnt, c0_gnt}), 128'(2'b00));

        // Watchdog in GRANT, then in SENT
        do_reset();
        req = 2'b11;
        sample_check("to_idle"); tick();
        pulses = 0; held = 0;
        for (int i = 0; i < TO; i++) begin
            sample_check("to_run");
            chk($sformatf("to_pulse%0d", i), 128'(timeout_err), 128'(i == TO - 1));
            pulses += int'(timeout_err);
            held += int'(c0_gnt);
            tick();
        end
        chk("to_held", 128'(held), 128'(TO));
        chk("to_pulses", 128'(pulses), 128'(1));
        sample_check("to_after"); tick();
        chk("to_other", 128'({c1_gnt, c0_gnt}), 128'(2'b10));
        req = 2'b10; snd[1] = 1;
        sample_check("tos_send"); tick();
        snd[1] = 0; pulses = 0;
        for (int i = 0; i < TO; i++) begin
            sample_check("tos_run");
            pulses += int'(timeout_err);
            tick();
        end
        chk("tos_pulses", 128'(pulses), 128'(1));
        chk("tos_gnt", 128'(c1_gnt), 128'(0));

        // Reset while BUSY
        do_reset();
        req = 2'b01;
        sample_check("rb_idle"); tick();
        snd[0] = 1; sample_check("rb_send"); tick();
        snd[0] = 0; ip_busy = 1; sample_check("rb_sent"); tick();
        chk("rb_busy_gnt", 128'(c0_gnt), 128'(1));
        req = 2'b11; ram_complete = 1;
        reset_n = 0;
        #1;
        chk("rb_out", 128'(observe()), 128'(0));
        @(posedge clk); #1;
        reset_n = 1; ip_busy = 0; ram_complete = 0;
        model_reset();
        sample_check("rb_rel"); tick();
        chk("rb_first", 128'({c1_gnt, c0_gnt}), 128'(2'b01));

        // Randomised traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < 2; c++) begin
                if ($urandom_range(9) == 0) req[c] = ~req[c];
                snd[c]   = ($urandom_range(7) == 0);
                wr[c]    = 1'($urandom_range(1));
                wdat[c]  = 8'($urandom);
                waddr[c] = 8'($urandom);
                size[c]  = 16'($urandom);
                dest[c]  = $urandom;
                off[c]   = 3'($urandom);
                proto[c] = 8'($urandom);
            end
            if ($urandom_range(4) == 0) ip_busy = ~ip_busy;
            ram_complete = 1'($urandom_range(1));
            sample_check("rand");
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL tb_timeout got running want finished");
        $fatal(1);
    end

endmodule
